// File: rtl/jtag_uart_echo.sv
// Polls a JTAG UART over Avalon-MM and echoes every received byte back out,
// optionally upper-casing ASCII letters on the way.
module jtag_uart_echo #(
  parameter int POLL_GAP  = 16,
  parameter bit UPPERCASE = 1'b0
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        enable,
  output logic        avm_chipselect,
  output logic        avm_address,
  output logic        avm_read_n,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic [15:0] rx_count,
  output logic [15:0] tx_count,
  output logic [7:0]  last_char,
  output logic        busy
);

  localparam int CW = (POLL_GAP > 2) ? $clog2(POLL_GAP) : 1;
  // GAP lasts POLL_GAP cycles (at least one); the counter runs 0..GAP_LAST
  localparam logic [CW-1:0] GAP_LAST = (POLL_GAP > 0) ? CW'(POLL_GAP - 1) : '0;

  typedef enum logic [1:0] {GAP, RD_DATA, RD_CTRL, WR_DATA} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] gap_cnt;
  logic          pend_vld;
  logic [7:0]    pend_byte;
  logic [7:0]    echo_byte;
  logic          xfer_done;
  logic          gap_exp;
  logic          rx_take;
  logic          tx_done;
  logic          unused_rd;

  assign xfer_done = avm_chipselect && !avm_waitrequest;
  assign gap_exp   = (gap_cnt == GAP_LAST);
  assign rx_take   = (state == RD_DATA) && xfer_done && avm_readdata[15];
  assign tx_done   = (state == WR_DATA) && xfer_done;
  assign unused_rd = ^avm_readdata[14:8];

  assign echo_byte = (UPPERCASE && pend_byte >= 8'h61 && pend_byte <= 8'h7A)
                   ? pend_byte - 8'h20 : pend_byte;

  // Bus signals decode straight from the state register, so they stay
  // frozen for as long as the slave stalls.
  assign avm_chipselect = (state != GAP);
  assign avm_address    = (state == RD_CTRL);
  assign avm_read_n     = !((state == RD_DATA) || (state == RD_CTRL));
  assign avm_write_n    = (state != WR_DATA);
  assign avm_writedata  = {24'h0, (state == WR_DATA) ? echo_byte : 8'h00};
  assign busy           = (state != GAP) || pend_vld;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) state <= GAP;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      GAP: begin
        // a pending byte always retries the control read, even when disabled
        if (gap_exp) begin
          if (pend_vld)    state_nxt = RD_CTRL;
          else if (enable) state_nxt = RD_DATA;
        end
      end
      RD_DATA: if (xfer_done) state_nxt = avm_readdata[15] ? RD_CTRL : GAP;
      RD_CTRL: if (xfer_done) state_nxt = (|avm_readdata[31:16]) ? WR_DATA : GAP;
      WR_DATA: if (xfer_done) state_nxt = GAP;
      default: state_nxt = GAP;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      gap_cnt   <= '0;
      pend_vld  <= 1'b0;
      pend_byte <= 8'h00;
      rx_count  <= 16'h0000;
      tx_count  <= 16'h0000;
      last_char <= 8'h00;
    end else begin
      // counter restarts on every GAP entry and parks at expiry while idle
      if (state != GAP)  gap_cnt <= '0;
      else if (!gap_exp) gap_cnt <= gap_cnt + CW'(1);
      if (rx_take) begin
        pend_vld  <= 1'b1;
        pend_byte <= avm_readdata[7:0];
        last_char <= avm_readdata[7:0];
        rx_count  <= rx_count + 16'd1;
      end
      if (tx_done) begin
        pend_vld <= 1'b0;
        tx_count <= tx_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_jtag_uart_echo.sv
// Directed bench for jtag_uart_echo: a tiny register-file slave answers reads
// by address, and each step checks the bus and counters against fixed values.
module tb_jtag_uart_echo;

  localparam int PG = 3;

  logic        clk = 1'b0;
  logic        rst_n, en, wreq;
  logic [31:0] data_val, ctrl_val;
  logic        cs, addr, rd_n, wr_n, busy;
  logic [31:0] wd, rdata;
  logic [15:0] rxc, txc;
  logic [7:0]  lastc;

  logic        cs2, addr2, rd_n2, wr_n2, busy2;
  logic [31:0] wd2, rdata2;
  logic [15:0] rxc2, txc2;
  logic [7:0]  lastc2;

  int n_chk = 0;
  int n_pass = 0;
  int k;

  always #5 clk = ~clk;

  assign rdata  = addr  ? ctrl_val : data_val;
  assign rdata2 = addr2 ? 32'h0040_0000 : 32'h0000_8061;

  jtag_uart_echo #(.POLL_GAP(PG), .UPPERCASE(1'b0)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .enable(en),
    .avm_chipselect(cs), .avm_address(addr), .avm_read_n(rd_n),
    .avm_write_n(wr_n), .avm_writedata(wd), .avm_readdata(rdata),
    .avm_waitrequest(wreq), .rx_count(rxc), .tx_count(txc),
    .last_char(lastc), .busy(busy)
  );

  jtag_uart_echo #(.POLL_GAP(0), .UPPERCASE(1'b1)) dut_uc (
    .clk_clk(clk), .reset_reset_n(rst_n), .enable(1'b1),
    .avm_chipselect(cs2), .avm_address(addr2), .avm_read_n(rd_n2),
    .avm_write_n(wr_n2), .avm_writedata(wd2), .avm_readdata(rdata2),
    .avm_waitrequest(1'b0), .rx_count(rxc2), .tx_count(txc2),
    .last_char(lastc2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic bus(input string tag, input logic a, input logic r, input logic w,
                     input logic [31:0] d);
    chk(tag, {cs, addr, rd_n, wr_n, wd}, {1'b1, a, r, w, d});
  endtask

  task automatic wait_cs(input string tag, output int steps);
    steps = 0;
    do begin
      tick();
      steps++;
    end while (!cs && steps < 200);
    chk({tag, "_seen"}, cs, 1'b1);
  endtask

  task automatic wait_wr(input string tag);
    int n = 0;
    while (wr_n && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_seen"}, wr_n, 1'b0);
  endtask

  // five stalled cycles, then one completing cycle; stall re-armed afterwards
  task automatic stall(input string tag, input logic a, input logic r, input logic w,
                       input logic [31:0] d);
    for (int j = 0; j < 5; j++) begin
      bus(tag, a, r, w, d);
      tick();
    end
    bus(tag, a, r, w, d);
    wreq = 1'b0;
    tick();
    wreq = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; wreq = 1'b0; data_val = '0; ctrl_val = '0;
    tick(); tick();
    chk("rst_bus", {cs, addr, rd_n, wr_n, wd}, {1'b0, 1'b0, 1'b1, 1'b1, 32'h0});
    chk("rst_cnt", {rxc, txc, lastc, busy}, {16'h0, 16'h0, 8'h00, 1'b0});

    // basic echo
    data_val = 32'h0000_8041; ctrl_val = 32'h0040_0000; en = 1'b1; rst_n = 1'b1;
    wait_cs("first_poll", k);
    chk("first_poll_gap", 64'(k), 64'(PG));
    bus("rd_data", 1'b0, 1'b0, 1'b1, 32'h0);
    tick();
    bus("rd_ctrl", 1'b1, 1'b0, 1'b1, 32'h0);
    chk("rx_latch", {rxc, lastc, busy}, {16'd1, 8'h41, 1'b1});
    data_val = 32'h0;
    tick();
    bus("wr_data", 1'b0, 1'b1, 1'b0, 32'h0000_0041);
    tick();
    chk("echo_done", {cs, rxc, txc, lastc, busy}, {1'b0, 16'd1, 16'd1, 8'h41, 1'b0});

    // empty poll falls back to GAP
    wait_cs("empty_poll", k);
    chk("echo_gap", 64'(k), 64'(PG));
    bus("empty_rd", 1'b0, 1'b0, 1'b1, 32'h0);
    tick();
    chk("empty_to_gap", {cs, rxc}, {1'b0, 16'd1});

    // TX FIFO full for three control polls, enable dropped meanwhile
    data_val = 32'h0000_8042; ctrl_val = 32'h0;
    wait_cs("ff_rd", k);
    bus("ff_rd", 1'b0, 1'b0, 1'b1, 32'h0);
    tick();
    en = 1'b0; data_val = 32'h0;
    bus("ff_ctrl1", 1'b1, 1'b0, 1'b1, 32'h0);
    for (int i = 2; i <= 3; i++) begin
      wait_cs("ff_retry", k);
      chk("ff_retry_gap", 64'(k), 64'(PG + 1));
      bus("ff_ctrl_retry", 1'b1, 1'b0, 1'b1, 32'h0);
    end
    tick();
    ctrl_val = 32'h0001_0000;
    wait_cs("ff_ctrl4", k);
    bus("ff_ctrl4", 1'b1, 1'b0, 1'b1, 32'h0);
    tick();
    bus("ff_wr", 1'b0, 1'b1, 1'b0, 32'h0000_0042);
    tick();
    chk("ff_cnt", {cs, rxc, txc, busy}, {1'b0, 16'd2, 16'd2, 1'b0});
    repeat (10) tick();
    chk("disabled_idle", {cs, busy}, {1'b0, 1'b0});

    // waitrequest stalls every access; counter parked at expiry polls at once
    data_val = 32'h0000_8043; ctrl_val = 32'h0040_0000; wreq = 1'b1; en = 1'b1;
    wait_cs("st_rd", k);
    chk("held_expiry", 64'(k), 64'd1);
    chk("st_no_rx_yet", rxc, 16'd2);
    stall("st_rd", 1'b0, 1'b0, 1'b1, 32'h0);
    data_val = 32'h0;
    chk("st_rx", {rxc, lastc}, {16'd3, 8'h43});
    stall("st_ctrl", 1'b1, 1'b0, 1'b1, 32'h0);
    stall("st_wr", 1'b0, 1'b1, 1'b0, 32'h0000_0043);
    wreq = 1'b0;
    chk("st_done", {cs, txc}, {1'b0, 16'd3});

    // counter wrap from a preloaded 0xFFFF
    force dut.rx_count = 16'hFFFF;
    force dut.tx_count = 16'hFFFF;
    tick();
    release dut.rx_count;
    release dut.tx_count;
    chk("preload", {rxc, txc}, {16'hFFFF, 16'hFFFF});
    data_val = 32'h0000_8044;
    wait_wr("wrap_wr");
    chk("wrap_rx", {rxc, lastc, wd}, {16'h0000, 8'h44, 32'h0000_0044});
    data_val = 32'h0;
    tick();
    chk("wrap_tx", txc, 16'h0000);

    // reset while a write is stalled
    data_val = 32'h0000_8045;
    wait_wr("rw");
    data_val = 32'h0; wreq = 1'b1;
    tick();
    bus("rw_stall", 1'b0, 1'b1, 1'b0, 32'h0000_0045);
    rst_n = 1'b0;
    tick();
    chk("rst_mid_bus", {cs, addr, rd_n, wr_n, wd}, {1'b0, 1'b0, 1'b1, 1'b1, 32'h0});
    chk("rst_mid_cnt", {rxc, txc, lastc, busy}, {16'h0, 16'h0, 8'h00, 1'b0});
    rst_n = 1'b1; wreq = 1'b0;
    wait_cs("post_rst", k);
    chk("post_rst_gap", 64'(k), 64'(PG));
    bus("post_rst_rd", 1'b0, 1'b0, 1'b1, 32'h0);
    tick();
    chk("post_rst_cnt", {rxc, txc, cs}, {16'h0, 16'h0, 1'b0});

    // UPPERCASE instance with POLL_GAP=0
    k = 0;
    while (wr_n2 && k < 200) begin
      tick();
      k++;
    end
    chk("uc_wr_seen", wr_n2, 1'b0);
    chk("uc_wd", wd2, 32'h0000_0041);
    chk("uc_last", lastc2, 8'h61);
    tick();
    chk("pg0_gap", cs2, 1'b0);
    tick();
    chk("pg0_poll", {cs2, addr2, rd_n2}, {1'b1, 1'b0, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/jtag_uart_echo.md
JTAG_UART_ECHO -- requirements
Module: jtag_uart_echo

Interface
REQ-001 SHALL have parameter POLL_GAP, default 16, the number of idle cycles between bus transactions (0 is legal).
REQ-002 SHALL have parameter UPPERCASE, default 0; when 1, bytes 0x61-0x7A are echoed minus 0x20.
REQ-003 SHALL have port clk_clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port reset_reset_n, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL have port enable, input, 1, which permits new polls when high.
REQ-006 SHALL have port avm_chipselect, output, 1, the Avalon-MM chipselect to the JTAG UART slave.
REQ-007 SHALL have port avm_address, output, 1, where 0 is the data register and 1 is the control register.
REQ-008 SHALL have port avm_read_n, output, 1, the active-low read strobe.
REQ-009 SHALL have port avm_write_n, output, 1, the active-low write strobe.
REQ-010 SHALL have port avm_writedata, output, 32, the write data with the byte in [7:0] and [31:8]=0.
REQ-011 SHALL have port avm_readdata, input, 32, the read data.
REQ-012 SHALL have port avm_waitrequest, input, 1, the slave stall signal.
REQ-013 SHALL have port rx_count, output, 16, the number of bytes received.
REQ-014 SHALL have port tx_count, output, 16, the number of bytes echoed.
REQ-015 SHALL have port last_char, output, 8, the most recent byte received, untransformed.
REQ-016 SHALL have port busy, output, 1, high when the FSM is not in GAP or a byte is pending.

Function
REQ-017 SHALL use FSM states GAP, RD_DATA, RD_CTRL and WR_DATA.
REQ-018 SHALL, in GAP, count POLL_GAP cycles.
- At expiry with enable=1 and no byte pending, it goes to RD_DATA.
- At expiry with a byte pending, it goes to RD_CTRL regardless of enable.
- With enable=0 and no byte pending, it stays in GAP with the counter held at expiry.
REQ-019 SHALL drive strobes only in their states:
- RD_DATA: chipselect=1, read_n=0, address=0.
- RD_CTRL: chipselect=1, read_n=0, address=1.
- WR_DATA: chipselect=1, write_n=0, address=0.
- GAP: chipselect=0, read_n=1, write_n=1.
REQ-020 SHALL hold address, strobes and writedata stable while avm_waitrequest=1; a transaction completes in the first cycle with chipselect=1 and waitrequest=0.
REQ-021 SHALL sample avm_readdata in the completing cycle of a read (zero read latency).
REQ-022 SHALL handle RD_DATA completion as follows:
- If readdata[15] (RVALID)=1: latch readdata[7:0] into the pending register and last_char, increment rx_count, then go to RD_CTRL.
- Else go to GAP.
REQ-023 SHALL handle RD_CTRL completion as follows:
- If readdata[31:16] (WSPACE)!=0, go to WR_DATA.
- Else go to GAP with the byte still pending, retrying RD_CTRL after the gap.
REQ-024 SHALL, on WR_DATA completion, increment tx_count, clear pending and go to GAP.
REQ-025 SHALL apply the UPPERCASE transform to writedata only, never to last_char.
REQ-026 SHALL let rx_count and tx_count wrap from 0xFFFF to 0x0000 without saturation.
REQ-027 SHALL ignore enable falling mid-transaction: the active transaction and any pending echo complete first.
REQ-028 SHALL never issue read and write together and never have more than one transaction outstanding.
REQ-029 SHALL, with POLL_GAP=0, leave GAP after one cycle.

Reset
REQ-030 SHALL, with reset_reset_n=0 at a clk_clk edge, set:
- FSM to GAP with the gap counter at 0;
- chipselect=0, read_n=1, write_n=1, address=0, writedata=0;
- rx_count=0, tx_count=0, last_char=0, pending cleared, busy=0.
REQ-031 SHALL, on reset asserted mid-transaction (even with waitrequest=1), deassert all strobes on the next edge and drop the pending byte.
REQ-032 SHALL, after reset release with enable=1, start the first RD_DATA POLL_GAP cycles later.

Verification
REQ-033 SHALL cover a basic echo: data read returns 0x0000_8041, then control returns 0x0040_0000 -> one write of 0x0000_0041, rx_count=1, tx_count=1, last_char=0x41.
REQ-034 SHALL cover UPPERCASE=1: received 0x61 -> writedata 0x0000_0041 and last_char=0x61.
REQ-035 SHALL cover a full TX FIFO: WSPACE=0 for 3 polls then 0x0001 -> no data re-read, a single write after the 4th RD_CTRL, rx_count=1, tx_count=1.
REQ-036 SHALL cover waitrequest held high for 5 cycles on each access -> strobes, address and writedata stable throughout, and the next state entered only after waitrequest=0.
REQ-037 SHALL cover rx_count preloaded to 0xFFFF by 65535 echoes (or forced), then one byte -> rx_count=0x0000 and tx_count wraps likewise.
REQ-038 SHALL cover reset pulsed during WR_DATA with waitrequest=1 -> strobes deasserted next cycle, counters 0, no write completes, and polling resumes after POLL_GAP.
